// File: rtl/multi_player_win_screen_pkg.sv
// -----------------------------------------------------------------------------
// multi_player_win_screen_pkg
// Shared types and constants for the end-of-game winner screen.
//   state_t  : sequencer states (IDLE, EVAL, SHOW, DONE)
//   lives_t  : one player's lives counter at the default width
//   DEFAULT_HOLD_FRAMES : frames the result screen stays up (game timing)
// -----------------------------------------------------------------------------
package multi_player_win_screen_pkg;

   // Game-timing constants
   localparam int DEFAULT_LIVES_W     = 4;
   localparam int DEFAULT_HOLD_FRAMES = 180;   // 3 s at 60 Hz

   typedef logic [DEFAULT_LIVES_W-1:0] lives_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      SHOW = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/multi_player_win_screen_max_scan.sv
// -----------------------------------------------------------------------------
// multi_player_win_screen_max_scan
// Sequential argmax over a snapshot of per-player lives, one player per cycle.
// Ports:
//   clk, resetN : clock, asynchronous active-low reset
//   start       : one-cycle pulse; clears the scan, first player is examined
//                 on the following cycle
//   lives       : packed snapshot, player i at [i*LIVES_W +: LIVES_W]
//   mask        : active players (bit i = 1 takes part)
//   done        : one-cycle pulse after the last player has been examined
//   max_idx     : latched winner index (held until the next scan completes)
//   tie         : latched tie flag (held until the next scan completes)
// -----------------------------------------------------------------------------
module multi_player_win_screen_max_scan
#(
   parameter int NUM_PLAYERS = 4,
   parameter int LIVES_W     = 4
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic                             start,
   input  logic [NUM_PLAYERS*LIVES_W-1:0]   lives,
   input  logic [NUM_PLAYERS-1:0]           mask,
   output logic                             done,
   output logic [$clog2(NUM_PLAYERS)-1:0]   max_idx,
   output logic                             tie
);

   localparam int IDX_W = $clog2(NUM_PLAYERS);

   logic               running;
   logic [IDX_W-1:0]   idx;
   logic [LIVES_W-1:0] max_val;
   logic [IDX_W-1:0]   cand_idx;
   logic [1:0]         max_cnt;     // holders of max_val, saturating at 2
   logic [IDX_W-1:0]   first_idx;   // first active player seen
   logic [1:0]         act_cnt;     // active players seen, saturating at 2

   logic [LIVES_W-1:0] cur;
   logic               act;
   logic               last;
   logic [LIVES_W-1:0] nxt_max_val;
   logic [IDX_W-1:0]   nxt_cand_idx;
   logic [1:0]         nxt_max_cnt;
   logic [IDX_W-1:0]   nxt_first_idx;
   logic [1:0]         nxt_act_cnt;
   logic [IDX_W-1:0]   res_idx;
   logic               res_tie;

   // One scan step for the current player, plus the result it would give
   // if this is the last player.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      cur           = lives[idx*LIVES_W +: LIVES_W];
      act           = mask[idx];
      last          = (idx == IDX_W'(NUM_PLAYERS-1));
      nxt_max_val   = max_val;
      nxt_cand_idx  = cand_idx;
      nxt_max_cnt   = max_cnt;
      nxt_first_idx = first_idx;
      nxt_act_cnt   = act_cnt;

      if (act) begin
         if (act_cnt == 2'd0) nxt_first_idx = idx;
         if (act_cnt != 2'd2) nxt_act_cnt   = act_cnt + 2'd1;

         if (cur > max_val) begin
            nxt_max_val  = cur;
            nxt_cand_idx = idx;
            nxt_max_cnt  = 2'd1;
         end else if (cur == max_val && max_cnt != 2'd0 && max_cnt != 2'd2) begin
            nxt_max_cnt  = max_cnt + 2'd1;
         end
      end

      // max_cnt stays 0 only when no active player has lives above 0: a
      // lone active player still wins, otherwise it is a tie at index 0.
      if (nxt_max_cnt == 2'd0) begin
         res_tie = (nxt_act_cnt != 2'd1);
         res_idx = (nxt_act_cnt == 2'd1) ? nxt_first_idx : '0;
      end else begin
         res_tie = (nxt_max_cnt != 2'd1);
         res_idx = nxt_cand_idx;
      end
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         running   <= 1'b0;
         idx       <= '0;
         max_val   <= '0;
         cand_idx  <= '0;
         max_cnt   <= '0;
         first_idx <= '0;
         act_cnt   <= '0;
         done      <= 1'b0;
         max_idx   <= '0;
         tie       <= 1'b0;
      end else if (start) begin
         running   <= 1'b1;
         idx       <= '0;
         max_val   <= '0;
         cand_idx  <= '0;
         max_cnt   <= '0;
         first_idx <= '0;
         act_cnt   <= '0;
         done      <= 1'b0;
      end else if (running) begin
         max_val   <= nxt_max_val;
         cand_idx  <= nxt_cand_idx;
         max_cnt   <= nxt_max_cnt;
         first_idx <= nxt_first_idx;
         act_cnt   <= nxt_act_cnt;
         if (last) begin
            running <= 1'b0;
            done    <= 1'b1;
            max_idx <= res_idx;
            tie     <= res_tie;
         end else begin
            idx     <= idx + 1'b1;
         end
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/multi_player_win_screen.sv
// -----------------------------------------------------------------------------
// multi_player_win_screen
// End-of-game winner selector and result-screen sequencer for N players.
// A game_over rising edge snapshots lives/active_mask, a sequential scan
// finds the winner (or a tie), the matching screen layer is forwarded to the
// display mux for HOLD_FRAMES frames (or until skip), then return_to_menu
// pulses for one cycle.
// Ports:
//   clk, resetN     : clock, asynchronous active-low reset
//   game_over       : level; rising edge starts the sequence
//   start_of_frame  : one-cycle pulse per video frame
//   skip            : one-cycle key pulse, ends the result screen early
//   active_mask     : bit i = 1 when player i takes part
//   lives           : packed lives, player i at [i*LIVES_W +: LIVES_W]
//   DR_win, RGB_win : per-player winner-screen layers (packed)
//   DR_tie, RGB_tie : tie-screen layer
//   DR_winner, RGB_winner : registered layer to the display mux
//   winner_idx, tie : latched result
//   screen_active   : high while the result screen is shown
//   return_to_menu  : one-cycle pulse when the sequence ends
// -----------------------------------------------------------------------------
module multi_player_win_screen
   import multi_player_win_screen_pkg::*;
#(
   parameter int NUM_PLAYERS = 4,
   parameter int LIVES_W     = DEFAULT_LIVES_W,
   parameter int RGB_W       = 8,
   parameter int HOLD_FRAMES = DEFAULT_HOLD_FRAMES
) (
   input  logic                             clk,
   input  logic                             resetN,
   input  logic                             game_over,
   input  logic                             start_of_frame,
   input  logic                             skip,
   input  logic [NUM_PLAYERS-1:0]           active_mask,
   input  logic [NUM_PLAYERS*LIVES_W-1:0]   lives,
   input  logic [NUM_PLAYERS-1:0]           DR_win,
   input  logic [NUM_PLAYERS*RGB_W-1:0]     RGB_win,
   input  logic                             DR_tie,
   input  logic [RGB_W-1:0]                 RGB_tie,
   output logic                             DR_winner,
   output logic [RGB_W-1:0]                 RGB_winner,
   output logic [$clog2(NUM_PLAYERS)-1:0]   winner_idx,
   output logic                             tie,
   output logic                             screen_active,
   output logic                             return_to_menu
);

   localparam int FRAME_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   state_t                         state;
   state_t                         state_next;
   logic                           game_over_d;
   logic                           go;
   logic                           scan_start;
   logic                           scan_done;
   logic [NUM_PLAYERS*LIVES_W-1:0] lives_snap;
   logic [NUM_PLAYERS-1:0]         mask_snap;
   logic [FRAME_W-1:0]             frame_cnt;
   logic                           last_frame;
   logic                           sel_dr;
   logic [RGB_W-1:0]               sel_rgb;

   // game_over_d resets to 0, so a level held high across reset release
   // still yields exactly one go.
   assign go         = game_over & ~game_over_d;
   assign scan_start = (state == IDLE) && go;
   assign last_frame = start_of_frame && (frame_cnt == FRAME_W'(HOLD_FRAMES-1));

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) game_over_d <= 1'b0;
      else         game_over_d <= game_over;
   end

   // Snapshot: later changes on lives/active_mask cannot affect the result.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         lives_snap <= '0;
         mask_snap  <= '0;
      end else if (scan_start) begin
         lives_snap <= lives;
         mask_snap  <= active_mask;
      end
   end

   multi_player_win_screen_max_scan #(
      .NUM_PLAYERS (NUM_PLAYERS),
      .LIVES_W     (LIVES_W)
   ) u_max_scan (
      .clk     (clk),
      .resetN  (resetN),
      .start   (scan_start),
      .lives   (lives_snap),
      .mask    (mask_snap),
      .done    (scan_done),
      .max_idx (winner_idx),
      .tie     (tie)
   );

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) state <= IDLE;
      else         state <= state_next;
   end

   // ---- FSM: next state ----
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go)                  state_next = EVAL;
         EVAL:    if (scan_done)           state_next = SHOW;
         SHOW:    if (skip || last_frame)  state_next = DONE;
         DONE:                             state_next = IDLE;
         default:                          state_next = IDLE;
      endcase
   end

   // ---- FSM: outputs ----
   always_comb begin
      screen_active  = (state == SHOW);
      return_to_menu = (state == DONE);
   end

   // Frames shown so far; held at 0 outside SHOW.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)                frame_cnt <= '0;
      else if (state != SHOW)     frame_cnt <= '0;
      else if (start_of_frame)    frame_cnt <= frame_cnt + 1'b1;
   end

   always_comb begin
      sel_dr  = tie ? DR_tie  : DR_win[winner_idx];
      sel_rgb = tie ? RGB_tie : RGB_win[winner_idx*RGB_W +: RGB_W];
   end

   // Gated on state_next so the pixel register is already blank during DONE
   // and starts tracking on the first SHOW cycle.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         DR_winner  <= 1'b0;
         RGB_winner <= '0;
      end else if (state_next == SHOW) begin
         DR_winner  <= sel_dr;
         RGB_winner <= sel_rgb;
      end else begin
         DR_winner  <= 1'b0;
         RGB_winner <= '0;
      end
   end

endmodule

// File: tb/tb_multi_player_win_screen.sv
// -----------------------------------------------------------------------------
// tb_multi_player_win_screen
// Self-checking bench: directed vector table, hand-written multi-cycle
// sequences (hold timing, skip, re-trigger, reset mid-screen) and random
// games checked against a behavioural winner model.
// -----------------------------------------------------------------------------
module tb_multi_player_win_screen;
   import multi_player_win_screen_pkg::*;

   localparam int NP = 4;
   localparam int LW = 4;
   localparam int RW = 8;
   localparam int HF = 3;

   logic            clk = 1'b0;
   logic            resetN;
   logic            game_over;
   logic            start_of_frame;
   logic            skip;
   logic [NP-1:0]   active_mask;
   logic [NP*LW-1:0] lives;
   logic [NP-1:0]   DR_win;
   logic [NP*RW-1:0] RGB_win;
   logic            DR_tie;
   logic [RW-1:0]   RGB_tie;
   logic            DR_winner;
   logic [RW-1:0]   RGB_winner;
   logic [1:0]      winner_idx;
   logic            tie;
   logic            screen_active;
   logic            return_to_menu;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] lv;
      logic [3:0]  mask;
      logic [1:0]  winner;
      logic        tie;
   } vec_t;

   vec_t vecs[10];

   multi_player_win_screen #(
      .NUM_PLAYERS (NP),
      .LIVES_W     (LW),
      .RGB_W       (RW),
      .HOLD_FRAMES (HF)
   ) dut (
      .clk            (clk),
      .resetN         (resetN),
      .game_over      (game_over),
      .start_of_frame (start_of_frame),
      .skip           (skip),
      .active_mask    (active_mask),
      .lives          (lives),
      .DR_win         (DR_win),
      .RGB_win        (RGB_win),
      .DR_tie         (DR_tie),
      .RGB_tie        (RGB_tie),
      .DR_winner      (DR_winner),
      .RGB_winner     (RGB_winner),
      .winner_idx     (winner_idx),
      .tie            (tie),
      .screen_active  (screen_active),
      .return_to_menu (return_to_menu)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Winner rules: highest lives among active players; lowest index among
   // equals; ties when several share the maximum; all-zero only wins alone.
   function automatic void model(input logic [15:0] lv, input logic [3:0] m,
                                 output logic [1:0] w, output logic t);
      lives_t v[NP];
      int best = 0, nact = 0, only = 0, nbest = 0, first_best = 0;
      for (int i = 0; i < NP; i++) begin
         v[i] = lv[i*LW +: LW];
         if (m[i]) begin
            nact++;
            only = i;
            if (int'(v[i]) > best) best = int'(v[i]);
         end
      end
      for (int i = NP-1; i >= 0; i--)
         if (m[i] && int'(v[i]) == best) begin
            nbest++;
            first_best = i;
         end
      if (nact == 0)       begin w = 2'd0;       t = 1'b1; end
      else if (best == 0)  begin w = (nact == 1) ? 2'(only) : 2'd0; t = (nact != 1); end
      else                 begin w = 2'(first_best); t = (nbest > 1); end
   endfunction

   task automatic wait_show(output int n);
      n = 0;
      while (!screen_active && n < 20) begin
         tick();
         n++;
      end
   endtask

   // Presents a game_over rising edge and checks scan latency and result.
   task automatic start_game(input logic [15:0] lv, input logic [3:0] m,
                             input logic [1:0] ew, input logic et,
                             input string name, input bit perturb);
      int n;
      lives = lv;
      active_mask = m;
      game_over = 1'b1;
      tick();
      if (perturb) begin
         lives = ~lv;
         active_mask = ~m;
      end
      wait_show(n);
      check({name, " latency"}, 64'(n), 64'(NP+1));
      check({name, " winner_idx"}, 64'(winner_idx), 64'(ew));
      check({name, " tie"}, 64'(tie), 64'(et));
   endtask

   task automatic check_pixel(input logic [1:0] ew, input logic et, input string name);
      logic       e_dr;
      logic [7:0] e_rgb;
      DR_win  = 4'($urandom);
      RGB_win = $urandom;
      DR_tie  = 1'($urandom);
      RGB_tie = 8'($urandom);
      e_dr  = et ? DR_tie  : DR_win[ew];
      e_rgb = et ? RGB_tie : RGB_win[ew*RW +: RW];
      tick();
      check({name, " DR_winner"}, 64'(DR_winner), 64'(e_dr));
      check({name, " RGB_winner"}, 64'(RGB_winner), 64'(e_rgb));
   endtask

   task automatic end_by_skip(input string name);
      skip = 1'b1;
      tick();
      skip = 1'b0;
      check({name, " done rtm"}, 64'(return_to_menu), 64'd1);
      check({name, " done active"}, 64'(screen_active), 64'd0);
      check({name, " done DR"}, 64'({DR_winner, RGB_winner}), 64'd0);
      tick();
      check({name, " rtm pulse"}, 64'(return_to_menu), 64'd0);
      game_over = 1'b0;
      tick();
   endtask

   initial begin
      logic [1:0]  ew;
      logic        et;
      logic [15:0] lv;
      logic [3:0]  m;
      int          seen;
      int          n;

      resetN = 1'b0;
      game_over = 1'b0;
      start_of_frame = 1'b0;
      skip = 1'b0;
      active_mask = '0;
      lives = '0;
      DR_win = '0;
      RGB_win = '0;
      DR_tie = 1'b0;
      RGB_tie = '0;

      #12;
      check("reset outputs", 64'({DR_winner, RGB_winner, winner_idx, tie, screen_active, return_to_menu}), 64'd0);
      repeat (2) tick();
      resetN = 1'b1;
      tick();
      check("idle after reset", 64'({screen_active, return_to_menu, DR_winner}), 64'd0);

      // ---- directed vectors: lives P3..P0 as hex nibbles ----
      vecs[0] = '{16'h0231, 4'b1111, 2'd1, 1'b0};   // distinct maximum
      vecs[1] = '{16'h0122, 4'b1111, 2'd0, 1'b1};   // tie at 2
      vecs[2] = '{16'h0122, 4'b1101, 2'd0, 1'b0};   // tie broken by mask
      vecs[3] = '{16'h5000, 4'b0111, 2'd0, 1'b1};   // all active at zero
      vecs[4] = '{16'h5000, 4'b0000, 2'd0, 1'b1};   // nobody active
      vecs[5] = '{16'h5000, 4'b0010, 2'd1, 1'b0};   // lone active at zero
      vecs[6] = '{16'h7321, 4'b1111, 2'd3, 1'b0};   // last player wins
      vecs[7] = '{16'h0333, 4'b1111, 2'd0, 1'b1};   // three-way tie
      vecs[8] = '{16'hF888, 4'b1111, 2'd3, 1'b0};   // unsigned max value
      vecs[9] = '{16'h4401, 4'b1111, 2'd2, 1'b1};   // tie between P2, P3
      for (int i = 0; i < 10; i++) begin
         start_game(vecs[i].lv, vecs[i].mask, vecs[i].winner, vecs[i].tie,
                    $sformatf("vec%0d", i), (i % 2) == 1);
         check_pixel(vecs[i].winner, vecs[i].tie, $sformatf("vec%0d", i));
         end_by_skip($sformatf("vec%0d", i));
      end

      // ---- hold timing: three frames then DONE ----
      start_game(16'h0231, 4'b1111, 2'd1, 1'b0, "hold", 1'b0);
      DR_win  = 4'b0010;
      RGB_win = 32'h0000_E000;
      DR_tie  = 1'b0;
      RGB_tie = 8'h11;
      tick();
      check("hold RGB E0", 64'(RGB_winner), 64'hE0);
      check("hold DR", 64'(DR_winner), 64'd1);
      for (int f = 0; f < HF; f++) begin
         start_of_frame = 1'b1;
         tick();
         start_of_frame = 1'b0;
         if (f < HF-1) begin
            check($sformatf("hold frame%0d active", f), 64'(screen_active), 64'd1);
            tick();
         end
      end
      check("hold done rtm", 64'(return_to_menu), 64'd1);
      check("hold done DR", 64'({DR_winner, RGB_winner}), 64'd0);
      tick();
      check("hold idle", 64'({return_to_menu, screen_active, DR_winner}), 64'd0);

      // game_over still high: no second sequence
      seen = 0;
      repeat (15) begin
         tick();
         if (screen_active) seen = 1;
      end
      check("no retrigger", 64'(seen), 64'd0);

      // toggle game_over: new sequence, skip after one frame
      game_over = 1'b0;
      tick();
      start_game(16'h0122, 4'b1101, 2'd0, 1'b0, "retrigger", 1'b0);
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
      check("skip after frame active", 64'(screen_active), 64'd1);
      end_by_skip("skip after frame");

      // skip coinciding with the final frame: one DONE only
      start_game(16'h7321, 4'b1111, 2'd3, 1'b0, "skip+sof", 1'b0);
      repeat (HF-1) begin
         start_of_frame = 1'b1;
         tick();
         start_of_frame = 1'b0;
         tick();
      end
      start_of_frame = 1'b1;
      skip = 1'b1;
      tick();
      start_of_frame = 1'b0;
      skip = 1'b0;
      check("skip+sof rtm", 64'(return_to_menu), 64'd1);
      tick();
      check("skip+sof single", 64'({return_to_menu, screen_active}), 64'd0);
      game_over = 1'b0;
      tick();

      // ---- random games against the model ----
      for (int r = 0; r < 25; r++) begin
         for (int p = 0; p < NP; p++) lv[p*LW +: LW] = 4'($urandom_range(0, 3));
         m = 4'($urandom_range(0, 15));
         model(lv, m, ew, et);
         start_game(lv, m, ew, et, $sformatf("rand%0d", r), 1'b1);
         check_pixel(ew, et, $sformatf("rand%0d", r));
         end_by_skip($sformatf("rand%0d", r));
      end

      // ---- asynchronous reset during SHOW ----
      start_game(16'h0231, 4'b1111, 2'd1, 1'b0, "rst", 1'b0);
      DR_win  = 4'hF;
      RGB_win = 32'hFFFF_FFFF;
      tick();
      check("rst pre DR", 64'(DR_winner), 64'd1);
      #2 resetN = 1'b0;
      #1;
      check("rst async outputs", 64'({DR_winner, RGB_winner, winner_idx, tie, screen_active, return_to_menu}), 64'd0);
      tick();
      resetN = 1'b1;
      tick();
      wait_show(n);
      check("rst restart latency", 64'(n), 64'(NP+1));
      check("rst restart winner", 64'(winner_idx), 64'd1);
      skip = 1'b1;
      tick();
      skip = 1'b0;
      check("rst restart done", 64'(return_to_menu), 64'd1);
      seen = 0;
      repeat (15) begin
         tick();
         if (screen_active) seen = 1;
      end
      check("rst single sequence", 64'(seen), 64'd0);
      game_over = 1'b0;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_player_win_screen.md
Name: multi_player_win_screen

Overview:
- End-of-game winner selector and screen sequencer for N-player modes; successor to the fixed 2-player winner mux.
- On a game_over rising edge it snapshots every active player's lives and scans them sequentially to find the maximum, detecting ties.
- It then drives the winner's (or the tie) screen layer into the drawing mux for a fixed number of frames, and pulses return_to_menu.

Parameters:
- NUM_PLAYERS, 4, number of player slots (2..8)
- LIVES_W, 4, width of one lives counter
- RGB_W, 8, pixel colour width
- HOLD_FRAMES, 180, frames the result screen is shown (>=1)

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- game_over  in  1  level from game controller; rising edge starts sequence
- start_of_frame  in  1  one-cycle pulse per video frame
- skip  in  1  one-cycle key pulse; ends the result screen early
- active_mask  in  NUM_PLAYERS  bit i=1: player i takes part
- lives  in  NUM_PLAYERS*LIVES_W  packed lives; player i at [i*LIVES_W +: LIVES_W]
- DR_win  in  NUM_PLAYERS  per-player winner-screen drawing request
- RGB_win  in  NUM_PLAYERS*RGB_W  packed per-player winner-screen pixels
- DR_tie  in  1  tie-screen drawing request
- RGB_tie  in  RGB_W  tie-screen pixel
- DR_winner  out  1  registered drawing request to the display mux
- RGB_winner  out  RGB_W  registered pixel to the display mux
- winner_idx  out  $clog2(NUM_PLAYERS)  latched winning player index
- tie  out  1  latched tie flag
- screen_active  out  1  high while in SHOW
- return_to_menu  out  1  one-cycle pulse when the sequence ends

Behaviour:
- Reset (asynchronous, resetN low): state=IDLE.
  - All outputs 0: DR_winner, RGB_winner, winner_idx, tie, screen_active, return_to_menu.
  - Snapshot, scan and frame counter cleared.
  - game_over edge-detect register cleared to 0.
- Edge detect: go = game_over & ~game_over_d. A game_over held high across reset release produces one go.
- IDLE, on go:
  - Register lives and active_mask into snapshot registers.
  - Clear scan state: max=0, max_idx=0, max_cnt=0, idx=0.
  - Enter EVAL. Later changes to lives or active_mask have no effect.
- EVAL: one player per cycle, idx = 0..NUM_PLAYERS-1. Inactive players are skipped.
  - If an active player's lives > max: max=lives, max_idx=idx, max_cnt=1.
  - If an active player's lives == max and max_cnt != 0: max_cnt++, saturating at 2.
  - A player with 0 lives can win only if every active player has 0 lives; that outcome is reported as a tie unless exactly one player is active.
  - On idx == NUM_PLAYERS-1, register the result using the final-cycle values and enter SHOW:
    - winner_idx = max_idx
    - tie = (max_cnt != 1)
  - If no player is active: tie=1, winner_idx=0.
  - EVAL lasts exactly NUM_PLAYERS cycles. screen_active rises NUM_PLAYERS+1 cycles after the clock edge that sampled go.
- SHOW:
  - screen_active=1.
  - Each cycle, DR_winner/RGB_winner are registered from:
    - tie=1: DR_tie/RGB_tie.
    - tie=0: DR_win[winner_idx] / RGB_win[winner_idx].
  - Pixel latency is 1 clock from the inputs.
  - frame_cnt increments on start_of_frame.
  - Leave to DONE on either condition:
    - start_of_frame && frame_cnt == HOLD_FRAMES-1
    - skip
  - skip and the final start_of_frame in the same cycle cause a single transition.
- DONE: lasts one cycle.
  - return_to_menu=1, screen_active=0, DR_winner=0, RGB_winner=0.
  - Then IDLE.
- Outside SHOW, DR_winner=0 and RGB_winner=0.
- winner_idx and tie hold their values until the next EVAL completes.
- A go during EVAL, SHOW or DONE is ignored, and no re-trigger occurs unless game_over falls and rises again.
- All lives comparisons are unsigned LIVES_W.

Decomposition:
- Shared package: state enum (IDLE, EVAL, SHOW, DONE) and a lives_t typedef logic [LIVES_W-1:0].
- HOLD_FRAMES default lives in the game-timing constants package.
- Sub-module max_scan: sequential argmax and tie counter with start, done, max_idx and tie ports. The top level keeps the FSM, frame counter and output mux.

Test Plan:
- Distinct maximum: NUM_PLAYERS=4, mask=1111, lives={1,3,2,0} (P0..P3), game_over rises.
  - Required: 4 EVAL cycles, then winner_idx=1, tie=0.
  - One cycle later, DR_winner/RGB_winner track DR_win[1]/RGB_win[1] (drive RGB_win[1]=8'hE0 → RGB_winner=8'hE0).
- Tie handling:
  - lives={2,2,1,0}, mask=1111 → tie=1, winner_idx=0, tie screen shown.
  - Same lives with mask=1101 → tie=0, winner_idx=0.
- Inactive and empty masks:
  - lives={0,0,0,5}, mask=0111 → tie=1, winner_idx=0 (all active at 0).
  - mask=0000 → tie=1, winner_idx=0.
- Hold timing: HOLD_FRAMES=3, three start_of_frame pulses in SHOW.
  - Required: DONE on the cycle after the 3rd pulse, return_to_menu high exactly 1 cycle, then IDLE with DR_winner=0.
  - skip in SHOW after 1 frame → immediate DONE.
- Snapshot and no re-trigger:
  - Change lives during EVAL/SHOW → result unchanged.
  - Keep game_over high after DONE → no second sequence.
  - Toggle game_over low then high → new sequence.
- Reset mid-operation: resetN low during SHOW.
  - Required: all outputs 0 immediately (asynchronous), state IDLE.
  - After release with game_over still high → exactly one new sequence.
